// File: rtl/vtiming_meas.sv
// Receive-side video timing measurement: recovers line period (min/max), last line
// index and a lock indication from the registered dphstart/dpvstart strobe pair.
module vtiming_meas #(
   parameter int CW         = 16,
   parameter int LOCKFRAMES = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          enable,
   input  logic          dphstart,
   input  logic          dpvstart,
   output logic [CW-1:0] hmin,
   output logic [CW-1:0] hmax,
   output logic [CW-1:0] vtot,
   output logic          locked,
   output logic          err,
   output logic          frame
);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_CHECK   = 2'd2;
   localparam logic [1:0] ST_LOCKED  = 2'd3;

   localparam logic [CW-1:0] C_ALL1 = {CW{1'b1}};

   logic [1:0]    r_state;
   logic [CW-1:0] r_lctr;
   logic [CW-1:0] r_yctr;
   logic [CW-1:0] r_curmin;
   logic [CW-1:0] r_curmax;
   logic [CW-1:0] r_hmin;
   logic [CW-1:0] r_hmax;
   logic [CW-1:0] r_vtot;
   logic [7:0]    r_matchcnt;
   logic          r_locked;
   logic          r_err;
   logic          r_frame;

   logic          w_fb;
   logic          w_bad;
   logic          w_ovf;
   logic [CW-1:0] w_period;
   logic [CW-1:0] w_fmin;
   logic [CW-1:0] w_fmax;
   logic          w_spreadOk;
   logic          w_match;
   logic [8:0]    w_cntNext;
   logic          w_reached;

   assign w_fb       = dphstart & dpvstart;
   assign w_bad      = dpvstart & ~dphstart;
   assign w_ovf      = (r_lctr == C_ALL1) | (r_yctr == C_ALL1);
   assign w_period   = r_lctr + CW'(1);
   // Frame min/max must include the period of the line closed by the current strobe.
   assign w_fmin     = (w_period < r_curmin) ? w_period : r_curmin;
   assign w_fmax     = (w_period > r_curmax) ? w_period : r_curmax;
   assign w_spreadOk = (w_fmax - w_fmin) <= CW'(1);
   assign w_match    = (w_fmin == r_hmin) && (w_fmax == r_hmax) &&
                       (r_yctr == r_vtot) && w_spreadOk;
   assign w_cntNext  = {1'b0, r_matchcnt} + 9'd1;
   assign w_reached  = (w_cntNext == 9'(LOCKFRAMES));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lctr <= '0;
         r_yctr <= '0;
      end else if (!enable) begin
         r_lctr <= '0;
         r_yctr <= '0;
      end else begin
         if (dphstart)
            r_lctr <= '0;
         else if (r_lctr != C_ALL1)
            r_lctr <= r_lctr + CW'(1);
         if (w_fb)
            r_yctr <= '0;
         else if (dphstart && (r_yctr != C_ALL1))
            r_yctr <= r_yctr + CW'(1);
      end
   end

   // Each frame boundary closes the old frame and restarts the accumulators.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_curmin <= '0;
         r_curmax <= '0;
      end else if (enable) begin
         if (w_fb) begin
            r_curmin <= C_ALL1;
            r_curmax <= '0;
         end else if (dphstart && (r_state != ST_SEARCH)) begin
            r_curmin <= w_fmin;
            r_curmax <= w_fmax;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_SEARCH;
         r_hmin     <= '0;
         r_hmax     <= '0;
         r_vtot     <= '0;
         r_matchcnt <= '0;
         r_locked   <= 1'b0;
         r_err      <= 1'b0;
         r_frame    <= 1'b0;
      end else begin
         r_frame <= 1'b0;
         if (!enable) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
         end else if (w_ovf || w_bad) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
         end else if (w_fb) begin
            if (r_state == ST_SEARCH) begin
               r_state <= ST_MEASURE;
            end else begin
               r_hmin  <= w_fmin;
               r_hmax  <= w_fmax;
               r_vtot  <= r_yctr;
               r_frame <= 1'b1;
               case (r_state)
                  ST_MEASURE: begin
                     r_matchcnt <= '0;
                     r_state    <= ST_CHECK;
                  end
                  ST_CHECK: begin
                     if (w_match) begin
                        r_matchcnt <= w_cntNext[7:0];
                        if (w_reached) begin
                           r_state  <= ST_LOCKED;
                           r_locked <= 1'b1;
                        end
                     end else begin
                        r_matchcnt <= '0;
                     end
                  end
                  default: begin
                     if (!w_match) begin
                        r_state    <= ST_CHECK;
                        r_locked   <= 1'b0;
                        r_matchcnt <= '0;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign hmin   = r_hmin;
   assign hmax   = r_hmax;
   assign vtot   = r_vtot;
   assign locked = r_locked;
   assign err    = r_err;
   assign frame  = r_frame;

endmodule

// File: tb/tb_vtiming_meas.sv
// Randomized self-checking bench for vtiming_meas against a frame-level behavioural model.
module tb_vtiming_meas;

   localparam int CW  = 16;
   localparam int LF  = 4;
   localparam int SAT = 65535;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic          dphstart = 1'b0;
   logic          dpvstart = 1'b0;
   logic [CW-1:0] hmin;
   logic [CW-1:0] hmax;
   logic [CW-1:0] vtot;
   logic          locked;
   logic          err;
   logic          frame;

   int nCompared = 0;
   int nMismatched = 0;

   // Model: phase 0 = waiting for first frame start, 1 = first frame, 2 = comparing frames.
   int mPhase, mGap, mLines, mHmin, mHmax, mVtot, mRun;
   bit mLocked, mErr, mFrame;
   int mPer[$];

   int dutFrames = 0;
   int capHmin = 0, capHmax = 0, capVtot = 0;

   always #5 clk = ~clk;

   vtiming_meas #(.CW(CW), .LOCKFRAMES(LF)) dut (
      .clk(clk), .resetn(resetn), .enable(enable),
      .dphstart(dphstart), .dpvstart(dpvstart),
      .hmin(hmin), .hmax(hmax), .vtot(vtot),
      .locked(locked), .err(err), .frame(frame)
   );

   task automatic modelReset();
      mPhase = 0; mGap = 0; mLines = 0; mHmin = 0; mHmax = 0; mVtot = 0; mRun = 0;
      mLocked = 0; mErr = 0; mFrame = 0;
      mPer.delete();
   endtask

   task automatic modelStep(bit en, bit h, bit v);
      int p, mn, mx;
      bit ovf, match;
      mFrame = 0;
      if (!en) begin
         mPhase = 0; mLocked = 0; mErr = 0; mGap = 0; mLines = 0;
         mPer.delete();
         return;
      end
      ovf = (mGap >= SAT) || (mLines >= SAT);
      p = mGap + 1;
      if (ovf || (v && !h)) begin
         mErr = 1; mPhase = 0; mLocked = 0;
      end else if (h && v) begin
         if (mPhase == 0) begin
            mPhase = 1;
         end else begin
            mPer.push_back(p);
            mn = mPer[0]; mx = mPer[0];
            foreach (mPer[i]) begin
               if (mPer[i] < mn) mn = mPer[i];
               if (mPer[i] > mx) mx = mPer[i];
            end
            match = (mn == mHmin) && (mx == mHmax) && (mLines == mVtot) && ((mx - mn) <= 1);
            if (mPhase == 1) mRun = 0;
            else if (match) begin
               if (!mLocked) begin
                  mRun++;
                  if (mRun == LF) mLocked = 1;
               end
            end else begin
               mRun = 0; mLocked = 0;
            end
            mHmin = mn; mHmax = mx; mVtot = mLines; mFrame = 1; mPhase = 2;
         end
         mPer.delete();
      end else if (h && mPhase != 0) begin
         mPer.push_back(p);
      end
      if (h) mGap = 0; else if (mGap < SAT) mGap++;
      if (h && v) mLines = 0; else if (h && mLines < SAT) mLines++;
   endtask

   task automatic checkOutput();
      nCompared++;
      if (hmin !== CW'(mHmin) || hmax !== CW'(mHmax) || vtot !== CW'(mVtot) ||
          locked !== mLocked || err !== mErr || frame !== mFrame) begin
         nMismatched++;
         $display("[TB] FAIL cycleCheck t=%0t dut hmin=%0d hmax=%0d vtot=%0d locked=%0b err=%0b frame=%0b required hmin=%0d hmax=%0d vtot=%0d locked=%0b err=%0b frame=%0b",
                  $time, hmin, hmax, vtot, locked, err, frame,
                  mHmin, mHmax, mVtot, mLocked, mErr, mFrame);
      end
   endtask

   task automatic expectLit(string name, int act, int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(bit h, bit v);
      dphstart = h;
      dpvstart = v;
      @(posedge clk);
      if (resetn) modelStep(enable, h, v);
      else modelReset();
      #1;
      checkOutput();
      if (frame) begin
         dutFrames++;
         capHmin = int'(hmin); capHmax = int'(hmax); capVtot = int'(vtot);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
   endtask

   // mode 0: constant period, 1: base/base+1 dither, 2: random period per line
   task automatic sendFrame(int nLines, int base, int mode);
      int per;
      for (int k = 0; k < nLines; k++) begin
         if (mode == 0) per = base;
         else if (mode == 1) per = base + (k % 2);
         else per = int'($urandom_range(1, base + 2));
         applyStimulus(1'b1, k == 0);
         idle(per - 1);
      end
   endtask

   task automatic enablePulse();
      enable = 1'b0;
      applyStimulus(1'b0, 1'b0);
      enable = 1'b1;
   endtask

   initial begin
      int f0, nl, bs, md, r;
      modelReset();
      idle(3);
      expectLit("resetHmin", int'(hmin), 0);
      expectLit("resetVtot", int'(vtot), 0);
      expectLit("resetLocked", int'(locked), 0);
      expectLit("resetFrame", int'(frame), 0);
      resetn = 1'b1;
      enable = 1'b1;
      idle(4);

      // Constant 10-cycle lines, 5 lines per frame
      sendFrame(5, 10, 0);
      expectLit("noFrameAfterFb1", dutFrames, 0);
      sendFrame(5, 10, 0);
      expectLit("firstFrameCount", dutFrames, 1);
      expectLit("constHmin", capHmin, 10);
      expectLit("constHmax", capHmax, 10);
      expectLit("constVtot", capVtot, 4);
      for (int i = 0; i < 3; i++) sendFrame(5, 10, 0);
      expectLit("unlockedAfterFb5", int'(locked), 0);
      sendFrame(5, 10, 0);
      expectLit("lockedAfterFb6", int'(locked), 1);
      sendFrame(5, 10, 0);
      expectLit("stillLocked", int'(locked), 1);

      // Dithered 10/11 lines
      enablePulse();
      sendFrame(5, 10, 1);
      sendFrame(5, 10, 1);
      expectLit("ditherHmin", capHmin, 10);
      expectLit("ditherHmax", capHmax, 11);
      for (int i = 0; i < 3; i++) sendFrame(5, 10, 1);
      expectLit("ditherUnlockedFb5", int'(locked), 0);
      sendFrame(5, 10, 1);
      expectLit("ditherLockedFb6", int'(locked), 1);

      // Switch to 6-line frames
      sendFrame(6, 10, 1);
      sendFrame(6, 10, 1);
      expectLit("sixLineUnlock", int'(locked), 0);
      expectLit("sixLineVtot", capVtot, 5);
      for (int i = 0; i < 3; i++) sendFrame(6, 10, 1);
      expectLit("sixLineNotYet", int'(locked), 0);
      sendFrame(6, 10, 1);
      expectLit("sixLineRelock", int'(locked), 1);

      // Stray frame strobe without line strobe
      idle(3);
      applyStimulus(1'b0, 1'b1);
      expectLit("strayErr", int'(err), 1);
      expectLit("strayLocked", int'(locked), 0);
      f0 = dutFrames;
      sendFrame(6, 10, 1);
      expectLit("strayNoFrame", dutFrames, f0);
      sendFrame(6, 10, 1);
      expectLit("strayFrameAfter2", dutFrames, f0 + 1);
      for (int i = 0; i < 4; i++) sendFrame(6, 10, 1);
      expectLit("lockedBeforeReset", int'(locked), 1);

      // Asynchronous reset mid-frame
      idle(20);
      #2;
      resetn = 1'b0;
      #1;
      expectLit("asyncHmin", int'(hmin), 0);
      expectLit("asyncLocked", int'(locked), 0);
      expectLit("asyncErr", int'(err), 0);
      modelReset();
      idle(3);
      resetn = 1'b1;
      f0 = dutFrames;
      sendFrame(5, 10, 0);
      expectLit("postResetNoFrame", dutFrames, f0);
      sendFrame(5, 10, 0);
      expectLit("postResetFrame", dutFrames, f0 + 1);

      // Randomized groups of frames with occasional disturbances
      for (int g = 0; g < 20; g++) begin
         nl = int'($urandom_range(1, 7));
         bs = int'($urandom_range(2, 13));
         r  = int'($urandom_range(0, 9));
         md = (r < 5) ? 0 : (r < 8) ? 1 : 2;
         for (int f = 0; f < 8; f++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
               idle(int'($urandom_range(0, 3)));
               applyStimulus(1'b0, 1'b1);
            end else if (r == 1) begin
               idle(int'($urandom_range(0, 3)));
               enablePulse();
            end
            sendFrame(nl, bs, md);
         end
      end

      // Line counter saturation
      sendFrame(1, 1, 0);
      idle(SAT + 5);
      expectLit("satErr", int'(err), 1);
      expectLit("satLocked", int'(locked), 0);
      enablePulse();
      expectLit("enableClearsErr", int'(err), 0);
      idle(5);
      expectLit("errStaysClear", int'(err), 0);
      for (int i = 0; i < 3; i++) sendFrame(5, 10, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/vtiming_meas.md
Name: vtiming_meas

Overview:
- Receive-side counterpart of the pixel-clock timing generator.
- Observes the registered dphstart/dpvstart strobe pair and recovers the line period (clk cycles, min/max per frame) and vtot (last line index, 0-based).
- Declares lock once the timing is stable over consecutive frames.
- Sits on the sink/loopback path; its outputs feed status registers and the DMA/frame-sync logic.

Parameters:
CW, 16, width of line-period and line counters
LOCKFRAMES, 4, consecutive matching frames required for lock (1..255)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  measurement enable; low forces SEARCH
dphstart  input  1  line-start strobe, 1 cycle
dpvstart  input  1  frame-start strobe; valid only coincident with dphstart
hmin  output  CW  shortest line period of last completed frame (cycles)
hmax  output  CW  longest line period of last completed frame (cycles)
vtot  output  CW  last line index of last completed frame (lines-1)
locked  output  1  timing stable
err  output  1  sticky protocol/overflow error, cleared by resetn or enable low
frame  output  1  1-cycle pulse, cycle after each frame boundary where outputs update

Behaviour:
- Reset (resetn=0, async): state SEARCH. All counters 0. hmin/hmax/vtot=0. locked=0, err=0, frame=0.
- Definitions:
  - line boundary (LB) = dphstart=1.
  - frame boundary (FB) = dphstart=1 and dpvstart=1.
  - dpvstart=1 with dphstart=0 is an error: err<=1, state->SEARCH, locked<=0.
- Line period: lctr clears to 0 on each LB, else increments, saturating at all-ones. At an LB, period p = lctr+1. p is valid only if a previous LB was seen in the current frame or at the FB that started it.
- Per-frame accumulators:
  - curmin/curmax updated with p at every valid LB, including the LB that is the next FB.
  - yctr: +1 on LB without dpvstart; <=0 on FB.
  - At FB, measured vtot = yctr.
- Overflow: lctr or yctr reaching all-ones sets err<=1, state->SEARCH, locked<=0.
- States:
  - SEARCH: ignore LBs until an FB, then clear accumulators and go to MEASURE.
  - MEASURE: at the next FB, register hmin/hmax/vtot from curmin/curmax/yctr, pulse frame, matchcnt<=0, go to CHECK.
  - CHECK: at each FB, compare the new frame (curmin, curmax, yctr) with the registered hmin/hmax/vtot.
    - Match requires all three equal and curmax-curmin<=1.
    - On match: matchcnt+1; when matchcnt+1 == LOCKFRAMES, go to LOCKED and set locked<=1.
    - On mismatch: matchcnt<=0, stay in CHECK.
    - Outputs are re-registered with the new frame values in either case; frame pulses.
  - LOCKED: same compare at each FB. On mismatch: locked<=0, matchcnt<=0, go to CHECK. Outputs and frame update as in CHECK.
- Tolerance: a one-cycle spread between min and max is allowed (fractional pixel-clock dithering). A spread greater than 1 never matches.
- Update timing: all registered outputs update on the clock edge that samples the FB, so they are visible the following cycle. frame is high for exactly that one following cycle. locked changes on the same edge.
- Simultaneous events:
  - enable low has priority over everything: state SEARCH, locked=0, err=0, outputs hold.
  - An FB that arrives together with an overflow condition is treated as overflow.
- Reset mid-frame: full clear; the next lock needs a fresh SEARCH.

Test Plan:
- Constant period 10 cycles, 5 lines/frame (FB every 50 cycles), LOCKFRAMES=4 -> first frame pulse at the 2nd FB with hmin=hmax=10, vtot=4; locked rises after the 6th FB and stays high.
- Dithered period alternating 10/11 in a 5-line frame, repeating pattern -> hmin=10, hmax=11, locks after the same frame count.
- Lock, then one frame with 6 lines -> at that FB locked drops and vtot=5; if 6 lines persist, relock after LOCKFRAMES further FBs.
- dpvstart pulsed without dphstart while locked -> err=1 and locked=0 next cycle; no frame pulse until SEARCH/MEASURE completes two FBs.
- No dphstart for 65535+ cycles -> lctr saturates, err=1, state SEARCH; toggle enable low for one cycle -> err=0.
- Assert resetn low mid-frame while locked -> outputs immediately 0 (async); after release, the first frame pulse occurs at the 2nd FB.
